// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues one req/ack instruction-memory access per fetch phase,
// and registers inst/curr_pc_fd/next_pc_fd for decode. Optional macro FETCH_TIMEOUT_EN adds an ack timeout.
module instruction_fetch #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]      NOP_INST     = 32'h0000_0013,
  parameter int               TIMEOUT_CYC  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            phase_fetch,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            fetch_done,
  output logic            stall_fetch,
`ifdef FETCH_TIMEOUT_EN
  output logic            fetch_timeout,
`endif
  output logic            misalign_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;
`endif

  // A redirect arriving with the fetch pulse wins over the held PC.
  assign fetch_pc    = jump_valid ? jump_pc : pc;
  assign stall_fetch = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= RESET_VECTOR;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_VECTOR;
      inst         <= NOP_INST;
      curr_pc_fd   <= RESET_VECTOR;
      next_pc_fd   <= RESET_VECTOR + PC_STEP;
      fetch_done   <= 1'b0;
      misalign_err <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt      <= '0;
      fetch_timeout <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low each cycle; branches below only raise them,
      // and all state uses non-blocking assignment so every branch sees pre-edge values.
      fetch_done   <= 1'b0;
      misalign_err <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (jump_valid) pc <= jump_pc;
          if (phase_fetch) begin
            if (fetch_pc[1:0] != 2'b00) begin
              inst         <= NOP_INST;
              curr_pc_fd   <= fetch_pc;
              next_pc_fd   <= fetch_pc + PC_STEP;
              misalign_err <= 1'b1;
              fetch_done   <= 1'b1;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
              state     <= ST_BUSY;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
          end
        end

        ST_BUSY: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
            if (jump_valid) begin
              inst <= NOP_INST;
              pc   <= jump_pc;
            end else begin
              inst       <= imem_rdata;
              curr_pc_fd <= imem_addr;
              next_pc_fd <= imem_addr + PC_STEP;
              pc         <= imem_addr + PC_STEP;
              fetch_done <= 1'b1;
            end
          end else if (jump_valid) begin
            // Memory still owes us a word; keep req up and drop it in FLUSH.
            pc    <= jump_pc;
            state <= ST_FLUSH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            imem_req      <= 1'b0;
            inst          <= NOP_INST;
            fetch_timeout <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        ST_FLUSH: begin
          if (jump_valid) pc <= jump_pc;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
`ifdef FETCH_TIMEOUT_EN
          end else if (wait_cnt == WAIT_LAST) begin
            imem_req      <= 1'b0;
            inst          <= NOP_INST;
            fetch_timeout <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        default: begin
          imem_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: handshake timing, redirects,
// misalignment, PC wrap and mid-request reset; timeout path when FETCH_TIMEOUT_EN is defined.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        phase_fetch;
  logic        jump_valid;
  logic [31:0] jump_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic [31:0] next_pc_fd;
  logic        fetch_done;
  logic        stall_fetch;
  logic        misalign_err;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .phase_fetch  (phase_fetch),
    .jump_valid   (jump_valid),
    .jump_pc      (jump_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .inst         (inst),
    .curr_pc_fd   (curr_pc_fd),
    .next_pc_fd   (next_pc_fd),
    .fetch_done   (fetch_done),
    .stall_fetch  (stall_fetch),
`ifdef FETCH_TIMEOUT_EN
    .fetch_timeout(fetch_timeout),
`endif
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; phase_fetch = 1'b0; jump_valid = 1'b0; jump_pc = '0;
    imem_rdata = '0; imem_ack = 1'b0;
    step(); step();
    check("rst_inst", inst, NOP);
    check("rst_curr", curr_pc_fd, 32'h0);
    check("rst_next", next_pc_fd, 32'h4);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_stall", {31'b0, stall_fetch}, 32'h0);
    check("rst_done", {31'b0, fetch_done}, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);

    // Fetch at 0 with ack in the first BUSY cycle.
    rst = 1'b0; phase_fetch = 1'b1;
    step();
    check("f0_req", {31'b0, imem_req}, 32'h1);
    check("f0_addr", imem_addr, 32'h0);
    check("f0_stall", {31'b0, stall_fetch}, 32'h1);
    phase_fetch = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    check("f0_inst", inst, 32'h0050_0093);
    check("f0_curr", curr_pc_fd, 32'h0);
    check("f0_next", next_pc_fd, 32'h4);
    check("f0_done", {31'b0, fetch_done}, 32'h1);
    check("f0_req_drop", {31'b0, imem_req}, 32'h0);
    imem_ack = 1'b0;
    step();
    check("f0_done_pulse", {31'b0, fetch_done}, 32'h0);

    // Fetch at 4 with ack delayed: stall spans five cycles.
    phase_fetch = 1'b1;
    step();
    check("f1_addr", imem_addr, 32'h4);
    phase_fetch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("f1_stall", {31'b0, stall_fetch}, 32'h1);
      check("f1_addr_hold", imem_addr, 32'h4);
      check("f1_inst_hold", inst, 32'h0050_0093);
      check("f1_no_done", {31'b0, fetch_done}, 32'h0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
    step();
    check("f1_stall_end", {31'b0, stall_fetch}, 32'h0);
    check("f1_inst", inst, 32'h00A0_0113);
    check("f1_curr", curr_pc_fd, 32'h4);
    check("f1_next", next_pc_fd, 32'h8);
    imem_ack = 1'b0;

    // Redirect while BUSY: flushed ack is discarded, next fetch goes to 0x100.
    phase_fetch = 1'b1;
    step();
    check("f2_addr", imem_addr, 32'h8);
    phase_fetch = 1'b0; jump_valid = 1'b1; jump_pc = 32'h100;
    step();
    jump_valid = 1'b0;
    check("fl_req_held", {31'b0, imem_req}, 32'h1);
    check("fl_stall", {31'b0, stall_fetch}, 32'h1);
    step(); step();
    check("fl_no_done", {31'b0, fetch_done}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("fl_done", {31'b0, fetch_done}, 32'h0);
    check("fl_inst", inst, 32'h00A0_0113);
    check("fl_req_drop", {31'b0, imem_req}, 32'h0);
    check("fl_stall_end", {31'b0, stall_fetch}, 32'h0);
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("f3_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    check("f3_curr", curr_pc_fd, 32'h100);
    check("f3_next", next_pc_fd, 32'h104);

    // Redirect coinciding with ack: data dropped, NOP presented, no done.
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("f4_addr", imem_addr, 32'h104);
    jump_valid = 1'b1; jump_pc = 32'h200; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    jump_valid = 1'b0; imem_ack = 1'b0;
    check("ja_done", {31'b0, fetch_done}, 32'h0);
    check("ja_inst", inst, NOP);
    check("ja_stall", {31'b0, stall_fetch}, 32'h0);
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("f5_addr", imem_addr, 32'h200);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
    step();
    imem_ack = 1'b0;

    // Misaligned redirect target.
    jump_valid = 1'b1; jump_pc = 32'h102;
    step();
    jump_valid = 1'b0; phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("ma_req", {31'b0, imem_req}, 32'h0);
    check("ma_err", {31'b0, misalign_err}, 32'h1);
    check("ma_done", {31'b0, fetch_done}, 32'h1);
    check("ma_inst", inst, NOP);
    check("ma_curr", curr_pc_fd, 32'h102);
    check("ma_next", next_pc_fd, 32'h106);
    check("ma_stall", {31'b0, stall_fetch}, 32'h0);
    step();
    check("ma_err_pulse", {31'b0, misalign_err}, 32'h0);

    // Redirect with fetch in the same cycle, at the top of the address space.
    jump_valid = 1'b1; jump_pc = 32'hFFFF_FFFC; phase_fetch = 1'b1;
    step();
    jump_valid = 1'b0; phase_fetch = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_ack = 1'b0;
    check("wr_curr", curr_pc_fd, 32'hFFFF_FFFC);
    check("wr_next", next_pc_fd, 32'h0);
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("wr_pc", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    step();
    imem_ack = 1'b0;

    // Reset mid-request; the late ack must be ignored.
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("rb_addr", imem_addr, 32'h4);
    rst = 1'b1;
    step();
    check("rb_req", {31'b0, imem_req}, 32'h0);
    check("rb_stall", {31'b0, stall_fetch}, 32'h0);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    imem_ack = 1'b0;
    check("rb_inst", inst, NOP);
    check("rb_curr", curr_pc_fd, 32'h0);
    check("rb_next", next_pc_fd, 32'h4);
    check("rb_done", {31'b0, fetch_done}, 32'h0);
    check("rb_stall2", {31'b0, stall_fetch}, 32'h0);
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("rb_pc", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    step();
    imem_ack = 1'b0;
    check("rb_after_inst", inst, 32'h4444_4444);

`ifdef FETCH_TIMEOUT_EN
    // Ack never arrives: timeout fires 64 edges after the request edge.
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    check("to_addr", imem_addr, 32'h4);
    for (int i = 1; i < 64; i++) begin
      step();
      check("to_early", {31'b0, fetch_timeout}, 32'h0);
    end
    step();
    check("to_pulse", {31'b0, fetch_timeout}, 32'h1);
    check("to_req", {31'b0, imem_req}, 32'h0);
    check("to_stall", {31'b0, stall_fetch}, 32'h0);
    check("to_inst", inst, NOP);
    step();
    check("to_pulse_end", {31'b0, fetch_timeout}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
